// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB bus arbiter: fixed-priority or round-robin grant with lock,
// split masking, default master and a bounded hold count against starvation.
module ahb_arbiter_param #(
  parameter int unsigned NUM_MASTERS    = 16,
  parameter int unsigned ARB_MODE       = 1,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [3:0]             HOLD_LAST = (MAX_HOLD == 0) ? 4'd0 : 4'(MAX_HOLD - 1);
  localparam logic [NUM_MASTERS-1:0] DEF_OH    = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] r_split_mask;
  logic [3:0]             r_owner;
  logic [3:0]             r_master;
  logic [3:0]             r_hold;
  logic                   r_mastlock;

  logic [NUM_MASTERS-1:0] w_elig;
  logic [NUM_MASTERS-1:0] w_master_oh;
  logic [NUM_MASTERS-1:0] w_next_oh;
  logic [NUM_MASTERS-1:0] w_split_set;
  logic                   w_others;
  logic                   w_any;
  logic                   w_own_lock;
  logic                   w_lock_now;
  logic [3:0]             w_pick_all;
  logic [3:0]             w_pick_excl;
  logic [3:0]             w_next_owner;
  logic [3:0]             w_next_hold;

  // r_grant is kept as the one-hot image of r_owner, so owner bit tests need no index decode
  assign w_elig     = HBUSREQx & ~r_split_mask;
  assign w_others   = |(w_elig & ~r_grant);
  assign w_any      = |w_elig;
  assign w_own_lock = |(HLOCKx & HBUSREQx & r_grant);
  assign w_lock_now = |(HLOCKx & r_grant);

  always_comb begin
    w_master_oh = '0;
    w_next_oh   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_master_oh[i] = (r_master == 4'(i));
      w_next_oh[i]   = (w_next_owner == 4'(i));
    end
  end

  assign w_split_set = (!HREADY && HRESP == 2'b11) ? (w_master_oh & ~DEF_OH) : '0;

  // Each candidate gets a priority distance; the smallest wins. In round-robin the
  // current owner sits at distance NUM_MASTERS so it is considered last.
  always_comb begin
    logic [4:0] d;
    logic [4:0] best_all;
    logic [4:0] best_excl;
    d           = '0;
    best_all    = '1;
    best_excl   = '1;
    w_pick_all  = DEF_IDX;
    w_pick_excl = DEF_IDX;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      if (ARB_MODE == 0)
        d = 5'(j);
      else if (4'(j) > r_owner)
        d = 5'(j) - {1'b0, r_owner};
      else
        d = 5'(j) + 5'(NUM_MASTERS) - {1'b0, r_owner};
      if (w_elig[j] && d < best_all) begin
        best_all   = d;
        w_pick_all = 4'(j);
      end
      if (w_elig[j] && !r_grant[j] && d < best_excl) begin
        best_excl   = d;
        w_pick_excl = 4'(j);
      end
    end
  end

  always_comb begin
    w_next_owner = r_owner;
    w_next_hold  = r_hold;
    if (!(r_mastlock || w_own_lock)) begin
      if (!w_any)
        w_next_owner = DEF_IDX;
      else if (MAX_HOLD != 0 && r_hold == HOLD_LAST && w_others)
        w_next_owner = w_pick_excl;
      else
        w_next_owner = w_pick_all;
      if (w_next_owner == r_owner && w_others)
        w_next_hold = (r_hold == 4'hF) ? r_hold : r_hold + 4'd1;
      else
        w_next_hold = '0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant      <= DEF_OH;
      r_owner      <= DEF_IDX;
      r_master     <= DEF_IDX;
      r_mastlock   <= 1'b0;
      r_hold       <= '0;
      r_split_mask <= '0;
    end else begin
      if (HREADY) begin
        r_grant    <= w_next_oh;
        r_owner    <= w_next_owner;
        r_hold     <= w_next_hold;
        r_master   <= r_owner;
        r_mastlock <= w_lock_now;
      end
      r_split_mask <= (r_split_mask | w_split_set) & ~HSPLIT;
    end
  end

  assign HGRANTx   = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule
